// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the MSB
// and stops at the first differing chunk. Signed or unsigned ordering, valid/ready on both sides.
module seq_mag_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [IDXW-1:0]  r_idx;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;

   logic [WIDTH-1:0] w_sign_mask;
   logic [CHUNK-1:0] w_chunk_a;
   logic [CHUNK-1:0] w_chunk_b;
   logic             w_accept;
   logic             w_last_chunk;

   // Bit WIDTH-1 only ever falls in the top chunk, so flipping it unconditionally in signed
   // mode is the same as flipping it only while the top chunk is under test.
   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      w_sign_mask            = '0;
      w_sign_mask[WIDTH-1]   = r_signed;
   end

   assign w_chunk_a    = CHUNK'((r_a ^ w_sign_mask) >> (32'(r_idx) * CHUNK));
   assign w_chunk_b    = CHUNK'((r_b ^ w_sign_mask) >> (32'(r_idx) * CHUNK));
   assign w_accept     = in_valid && in_ready;
   assign w_last_chunk = (r_idx == '0);

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next_state = COMPARE;
         COMPARE: if ((w_chunk_a != w_chunk_b) || w_last_chunk) w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= '0;
         r_eq     <= 1'b0;
         r_gt     <= 1'b0;
         r_lt     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_signed <= signed_mode;
                  r_idx    <= LAST_IDX;
               end
            end
            COMPARE: begin
               if (w_chunk_a > w_chunk_b) begin
                  {r_eq, r_gt, r_lt} <= 3'b010;
               end else if (w_chunk_a < w_chunk_b) begin
                  {r_eq, r_gt, r_lt} <= 3'b001;
               end else if (w_last_chunk) begin
                  {r_eq, r_gt, r_lt} <= 3'b100;
               end else begin
                  r_idx <= r_idx - IDXW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == COMPARE);
   assign out_valid = (r_state == DONE);
   assign eq        = r_eq;
   assign gt        = r_gt;
   assign lt        = r_lt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: three instances (CHUNK = 4, 16, 1) at WIDTH = 16,
// directed cases, backpressure, asynchronous reset mid-compare and random pairs per mode.
module tb_seq_mag_comparator;

   localparam int W    = 16;
   localparam int NDUT = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid    [NDUT];
   logic         in_ready    [NDUT];
   logic [W-1:0] a           [NDUT];
   logic [W-1:0] b           [NDUT];
   logic         signed_mode [NDUT];
   logic         out_valid   [NDUT];
   logic         out_ready   [NDUT];
   logic         eq          [NDUT];
   logic         gt          [NDUT];
   logic         lt          [NDUT];
   logic         busy        [NDUT];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      seq_mag_comparator #(
         .WIDTH(W),
         .CHUNK((g == 0) ? 4 : ((g == 1) ? 16 : 1))
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .a           (a[g]),
         .b           (b[g]),
         .signed_mode (signed_mode[g]),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .eq          (eq[g]),
         .gt          (gt[g]),
         .lt          (lt[g]),
         .busy        (busy[g])
      );
   end

   typedef struct {
      logic [2:0] res;   // {eq, gt, lt}
      int         lat;
   } exp_t;

   exp_t sb[$];

   function automatic int chunk_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
   endfunction

   function automatic exp_t model(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic sm);
      exp_t        e;
      int          c;
      int          n;
      logic [31:0] mask;
      logic [W-1:0] diff;
      bit          found;
      c     = chunk_of(d);
      n     = W / c;
      diff  = av ^ bv;
      found = 1'b0;
      if (sm) e.res = ($signed(av) == $signed(bv)) ? 3'b100 :
                      (($signed(av) > $signed(bv)) ? 3'b010 : 3'b001);
      else    e.res = (av == bv) ? 3'b100 : ((av > bv) ? 3'b010 : 3'b001);
      e.lat = n;
      for (int i = 0; i < n; i++) begin
         mask = ((32'd1 << c) - 32'd1) << (W - (i + 1) * c);
         if (!found && ((32'(diff) & mask) != 0)) begin
            e.lat = i + 1;
            found = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] outs(input int d);
      return 32'({in_ready[d], out_valid[d], busy[d], eq[d], gt[d], lt[d]});
   endfunction

   task automatic do_cmp(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input int stall, input string tag);
      exp_t       e;
      int         lat;
      int         busy_cnt;
      logic [2:0] held;
      lat      = 0;
      busy_cnt = 0;
      sb.push_back(model(d, av, bv, sm));
      @(negedge clk);
      check({tag, " ready"}, 32'(in_ready[d]), 32'h1);
      a[d] = av; b[d] = bv; signed_mode[d] = sm; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0; a[d] = ~av; b[d] = W'($urandom); signed_mode[d] = ~sm;
      while (!out_valid[d] && lat < 64) begin
         if (busy[d]) busy_cnt++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, " out_valid"}, 32'(out_valid[d]), 32'h1);
      held = {eq[d], gt[d], lt[d]};
      for (int i = 0; i < stall; i++) begin
         in_valid[d] = (i % 2 == 0);
         a[d] = W'($urandom);
         @(posedge clk);
         @(negedge clk);
         check({tag, " stall state"}, 32'({in_ready[d], out_valid[d]}), 32'h1);
         check({tag, " stall hold"}, 32'({eq[d], gt[d], lt[d]}), 32'(held));
      end
      in_valid[d] = 1'b0;
      e = sb.pop_front();
      check({tag, " result"}, 32'({eq[d], gt[d], lt[d]}), 32'(e.res));
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(e.lat));
      out_ready[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[d] = 1'b0;
      check({tag, " idle"}, 32'({in_ready[d], out_valid[d], busy[d]}), 32'h4);
      check({tag, " retained"}, 32'({eq[d], gt[d], lt[d]}), 32'(e.res));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      for (int d = 0; d < NDUT; d++) begin
         in_valid[d] = 1'b0; a[d] = '0; b[d] = '0; signed_mode[d] = 1'b0; out_ready[d] = 1'b0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < NDUT; d++) check($sformatf("reset outs dut%0d", d), outs(d), 32'h20);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases on the CHUNK=4 instance
      do_cmp(0, 16'h1234, 16'h1234, 1'b0, 0, "eq_unsigned");
      do_cmp(0, 16'h8000, 16'h7FFF, 1'b0, 0, "early_unsigned");
      do_cmp(0, 16'h8000, 16'h7FFF, 1'b1, 0, "early_signed");
      do_cmp(0, 16'hFFFF, 16'h0001, 1'b1, 0, "neg1_vs_1");
      do_cmp(0, 16'h12A4, 16'h12A5, 1'b0, 0, "lsb_diff");
      do_cmp(0, 16'h00F0, 16'h00E0, 1'b0, 5, "backpressure");
      @(negedge clk);
      check("bp nothing captured", 32'({in_ready[0], busy[0], out_valid[0]}), 32'h4);

      // Asynchronous reset while a compare is in flight
      @(negedge clk);
      a[0] = 16'h0001; b[0] = 16'h0000; signed_mode[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk);
      #2 in_valid[0] = 1'b0;
      check("pre-reset busy", 32'(busy[0]), 32'h1);
      #1 rst_n = 1'b0;
      #1 check("mid-op reset outs", outs(0), 32'h20);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post-reset ready", 32'(in_ready[0]), 32'h1);
      do_cmp(0, 16'h0000, 16'h0000, 1'b0, 0, "after_reset_eq");

      // Random pairs per instance and mode, biased toward equal and single-bit differences
      for (int d = 0; d < NDUT; d++) begin
         for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 200; n++) begin
               av = W'($urandom);
               case ($urandom_range(0, 3))
                  0:       bv = av;
                  1:       bv = av ^ (W'(1) << $urandom_range(0, W - 1));
                  default: bv = W'($urandom);
               endcase
               do_cmp(d, av, bv, m[0], $urandom_range(0, 2),
                      $sformatf("rand d%0d m%0d n%0d", d, m, n));
            end
         end
      end

      check("scoreboard drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
